// File: rtl/band_mixer_pkg.sv
// Shared equalizer definitions: sample widths, accumulator types and a saturate helper.
package band_mixer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = DATA_W + 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ATT_W  = 3;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Full-precision tree sum travelling with the attenuation captured for it
    typedef struct packed {
        acc_t             sum;
        logic [ATT_W-1:0] atten;
    } acc_word_t;

    localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);

    function automatic sample_t saturate(input acc_t x);
        if (x > SAT_MAX) begin
            return sample_t'(SAT_MAX);
        end else if (x < SAT_MIN) begin
            return sample_t'(SAT_MIN);
        end
        return sample_t'(x);
    endfunction

endpackage

// File: rtl/band_mixer_shift_sat.sv
// Stage-4 datapath: arithmetic attenuation shift, saturation and clip detect.
module mix_shift_sat
    import band_mixer_pkg::*;
(
    input  acc_word_t word,
    output sample_t   sat_c,
    output logic      clip_c
);

    acc_t shifted;

    // Arithmetic shift floors toward minus infinity for negative sums
    assign shifted = $signed(word.sum) >>> word.atten;
    assign sat_c   = saturate(shifted);
    assign clip_c  = (shifted > SAT_MAX) || (shifted < SAT_MIN);

endmodule

// File: rtl/band_mixer.sv
// Eight-band summing stage: pipelined adder tree, master attenuation, saturation, clip stats.
module band_mixer
    import band_mixer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] band_1,
    input  logic signed [DATA_W-1:0] band_2,
    input  logic signed [DATA_W-1:0] band_3,
    input  logic signed [DATA_W-1:0] band_4,
    input  logic signed [DATA_W-1:0] band_5,
    input  logic signed [DATA_W-1:0] band_6,
    input  logic signed [DATA_W-1:0] band_7,
    input  logic signed [DATA_W-1:0] band_8,
    input  logic [ATT_W-1:0]         atten,
    input  logic                     clip_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] mix_out,
    output logic                     clip_flag,
    output logic [CNT_W-1:0]         clip_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                     v1, v2, v3;
    logic signed [DATA_W:0]   s1 [4];
    logic signed [DATA_W+1:0] s2 [2];
    logic [ATT_W-1:0]         att1, att2;
    acc_word_t                w3;
    sample_t                  sat_c;
    logic                     clip_c;

    // Valid bits advance every cycle; data only loads behind a valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Stage 1: pair sums, sign-extended by one bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) s1[i] <= '0;
            att1 <= '0;
        end else if (in_valid) begin
            s1[0] <= {band_1[DATA_W-1], band_1} + {band_2[DATA_W-1], band_2};
            s1[1] <= {band_3[DATA_W-1], band_3} + {band_4[DATA_W-1], band_4};
            s1[2] <= {band_5[DATA_W-1], band_5} + {band_6[DATA_W-1], band_6};
            s1[3] <= {band_7[DATA_W-1], band_7} + {band_8[DATA_W-1], band_8};
            att1  <= atten;
        end
    end

    // Stage 2: quad sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2[0] <= '0;
            s2[1] <= '0;
            att2  <= '0;
        end else if (v1) begin
            s2[0] <= {s1[0][DATA_W], s1[0]} + {s1[1][DATA_W], s1[1]};
            s2[1] <= {s1[2][DATA_W], s1[2]} + {s1[3][DATA_W], s1[3]};
            att2  <= att1;
        end
    end

    // Stage 3: exact full sum in ACC_W bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w3 <= '0;
        end else if (v2) begin
            w3.sum   <= {s2[0][DATA_W+1], s2[0]} + {s2[1][DATA_W+1], s2[1]};
            w3.atten <= att2;
        end
    end

    mix_shift_sat u_shift_sat (
        .word   (w3),
        .sat_c  (sat_c),
        .clip_c (clip_c)
    );

    // Stage 4: registered output, holds through gaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mix_out   <= '0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                mix_out <= sat_c;
            end
        end
    end

    // A clip on the same edge as a clear restarts the count at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_flag  <= 1'b0;
            clip_count <= '0;
        end else if (v3 && clip_c) begin
            clip_flag <= 1'b1;
            if (clip_clr) begin
                clip_count <= CNT_W'(1);
            end else if (clip_count != CNT_MAX) begin
                clip_count <= clip_count + CNT_W'(1);
            end
        end else if (clip_clr) begin
            clip_flag  <= 1'b0;
            clip_count <= '0;
        end
    end

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer against an arithmetic reference model.
module tb_band_mixer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] band [8];
    logic [2:0]         atten;
    logic               clip_clr;
    logic               out_valid;
    logic signed [15:0] mix_out;
    logic               clip_flag;
    logic [15:0]        clip_count;

    always #5 clk = ~clk;

    band_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .band_1     (band[0]),
        .band_2     (band[1]),
        .band_3     (band[2]),
        .band_4     (band[3]),
        .band_5     (band[4]),
        .band_6     (band[5]),
        .band_7     (band[6]),
        .band_8     (band[7]),
        .atten      (atten),
        .clip_clr   (clip_clr),
        .out_valid  (out_valid),
        .mix_out    (mix_out),
        .clip_flag  (clip_flag),
        .clip_count (clip_count)
    );

    typedef struct {
        int due;
        int value;
        bit clip;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   last_out = 0;
    int   m_flag   = 0;
    int   m_count  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Division by 2^a rounded toward minus infinity
    function automatic int floor_shift(input int s, input int a);
        int d = 2 ** a;
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    // Apply current inputs for one clock edge, advance the model, then compare
    task automatic step();
        bit   v   = in_valid;
        bit   clr = clip_clr;
        int   s   = 0;
        int   r;
        bit   ev;
        exp_t e;
        if (v) begin
            for (int i = 0; i < 8; i++) s += int'(band[i]);
            r       = floor_shift(s, int'(atten));
            e.clip  = (r > 32767) || (r < -32768);
            e.value = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
            e.due   = cyc + 4;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        ev = (q.size() > 0) && (q[0].due == cyc);
        check("out_valid", int'(out_valid), int'(ev));
        if (ev) begin
            e = q.pop_front();
            check("mix_out", int'(mix_out), e.value);
            last_out = e.value;
        end else begin
            check("mix_hold", int'(mix_out), last_out);
        end
        if (ev && e.clip) begin
            m_flag  = 1;
            m_count = clr ? 1 : ((m_count == 65535) ? 65535 : m_count + 1);
        end else if (clr) begin
            m_flag  = 0;
            m_count = 0;
        end
        check("clip_flag", int'(clip_flag), m_flag);
        check("clip_count", int'(clip_count), m_count);
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < 8; i++) band[i] = 16'(val);
    endtask

    // One isolated sample followed by enough idle cycles for it to emerge
    task automatic send_flush(input int att);
        atten    = 3'(att);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_mix"}, int'(mix_out), 0);
        check({tag, "_flag"}, int'(clip_flag), 0);
        check({tag, "_count"}, int'(clip_count), 0);
    endtask

    initial begin
        bit [9:0] pat = 10'b1101110111;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        clip_clr = 1'b0;
        atten    = '0;
        set_all(0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum and exact 4-cycle latency
        set_all(1000);
        send_flush(0);
        check("t1_valid", int'(out_valid), 1);
        check("t1_mix", int'(mix_out), 8000);
        check("t1_count", int'(clip_count), 0);
        step();

        // Positive saturation, then exact limit after shift
        set_all(32767);
        send_flush(0);
        check("pos_sat_mix", int'(mix_out), 32767);
        check("pos_sat_flag", int'(clip_flag), 1);
        check("pos_sat_count", int'(clip_count), 1);
        send_flush(3);
        check("pos_lim_mix", int'(mix_out), 32767);
        check("pos_lim_count", int'(clip_count), 1);

        // Negative saturation, then exact limit after shift
        set_all(-32768);
        send_flush(0);
        check("neg_sat_mix", int'(mix_out), -32768);
        check("neg_sat_count", int'(clip_count), 2);
        send_flush(3);
        check("neg_lim_mix", int'(mix_out), -32768);
        check("neg_lim_count", int'(clip_count), 2);

        // Floor rounding of negative and positive values
        set_all(0);
        band[0] = 16'sd5;
        band[1] = -16'sd6;
        send_flush(1);
        check("floor_neg", int'(mix_out), -1);
        set_all(0);
        band[0] = 16'sd7;
        send_flush(2);
        check("floor_pos", int'(mix_out), 1);

        // Gapped stream with attenuation change mid-stream
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 8; i++) band[i] = 16'($urandom_range(0, 4000) - 2000);
            in_valid = pat[9-k];
            atten    = (k >= 5) ? 3'd2 : 3'd0;
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();

        // Reset with three samples in flight
        set_all(32767);
        atten    = 3'd0;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        last_out = 0;
        m_flag   = 0;
        m_count  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();

        // Clear alone, then clear coinciding with a clip event
        set_all(32767);
        send_flush(0);
        send_flush(0);
        check("pre_clr_count", int'(clip_count), 2);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        check("clr_only_count", int'(clip_count), 0);
        check("clr_only_flag", int'(clip_flag), 0);
        send_flush(0);
        send_flush(0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        check("clr_vs_clip_flag", int'(clip_flag), 1);
        check("clr_vs_clip_count", int'(clip_count), 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int mode = int'($urandom_range(0, 3));
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    0:       band[i] = 16'($urandom);
                    1:       band[i] = 16'($urandom_range(32000, 32767));
                    2:       band[i] = 16'(-int'($urandom_range(32000, 32768)));
                    default: band[i] = 16'($urandom_range(0, 200) - 100);
                endcase
            end
            in_valid = 1'($urandom_range(0, 3) != 0);
            atten    = 3'($urandom_range(0, 7));
            clip_clr = 1'($urandom_range(0, 19) == 0);
            step();
        end
        in_valid = 1'b0;
        clip_clr = 1'b0;
        repeat (5) step();

        // Drive the clip counter to its ceiling
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        set_all(32767);
        atten    = 3'd0;
        in_valid = 1'b1;
        repeat (65535) step();
        in_valid = 1'b0;
        repeat (4) step();
        check("cnt_full", int'(clip_count), 65535);
        send_flush(0);
        check("cnt_hold", int'(clip_count), 65535);
        check("cnt_hold_flag", int'(clip_flag), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
